// File: rtl/dmem_pkg.sv
// Shared definitions for the dmem responder slice.
//   - word/lane geometry
//   - canonical byte-enable masks
//   - fault-reason encoding used by assertion/coverage benches
//   - helpers: fault classification, mask-to-bit expansion
package dmem_pkg;

    localparam int DMEM_WORD_W = 32;
    localparam int DMEM_LANES  = 4;

    localparam logic [DMEM_LANES-1:0] DMEM_MASK_BYTE = 4'b0001;
    localparam logic [DMEM_LANES-1:0] DMEM_MASK_HALF = 4'b0011;
    localparam logic [DMEM_LANES-1:0] DMEM_MASK_WORD = 4'b1111;

    typedef enum logic [1:0] {
        FAULT_NONE     = 2'b00,
        FAULT_MISALIGN = 2'b01,
        FAULT_RANGE    = 2'b10,
        FAULT_BOTH     = 2'b11
    } dmem_fault_e;

    function automatic dmem_fault_e dmem_classify(input logic misaligned,
                                                  input logic out_of_range);
        return dmem_fault_e'({out_of_range, misaligned});
    endfunction

    // Expand a per-lane byte enable into a per-bit write mask.
    function automatic logic [DMEM_WORD_W-1:0] dmem_lane_bits(
        input logic [DMEM_LANES-1:0] mask);
        logic [DMEM_WORD_W-1:0] bits;
        bits = '0;
        for (int b = 0; b < DMEM_LANES; b++) begin
            bits[8*b +: 8] = {8{mask[b]}};
        end
        return bits;
    endfunction

endpackage

// File: rtl/dmem_rd_pipe.sv
// Fixed-latency response pipeline for dmem_responder.
// LATENCY stages of {valid, fault, data}; the last stage drives the response.
// Ports:
//   clk, rst_n           clock, async active-low reset (clears valid/fault)
//   req_valid/fault/data entry accepted this cycle
//   rsp_valid/fault/data response LATENCY cycles later
// Data only advances alongside a valid entry, so rsp_data holds the last
// returned word between responses. The final data stage is reset so the
// response bus reads 0 out of reset; inner data stages are not reset.
module dmem_rd_pipe
    import dmem_pkg::*;
#(
    parameter int LATENCY = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    input  logic                   req_fault,
    input  logic [DMEM_WORD_W-1:0] req_data,
    output logic                   rsp_valid,
    output logic                   rsp_fault,
    output logic [DMEM_WORD_W-1:0] rsp_data
);

    for (genvar g = 0; g < LATENCY; g++) begin : g_stage
        logic                   v;
        logic                   f;
        logic [DMEM_WORD_W-1:0] d;
        logic                   v_prev;
        logic                   f_prev;
        logic [DMEM_WORD_W-1:0] d_prev;

        if (g == 0) begin : g_head
            assign v_prev = req_valid;
            assign f_prev = req_fault;
            assign d_prev = req_data;
        end else begin : g_body
            assign v_prev = g_stage[g-1].v;
            assign f_prev = g_stage[g-1].f;
            assign d_prev = g_stage[g-1].d;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v <= 1'b0;
                f <= 1'b0;
            end else begin
                v <= v_prev;
                f <= f_prev;
            end
        end

        if (g == LATENCY - 1) begin : g_tail_data
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    d <= '0;
                end else if (v_prev) begin
                    d <= d_prev;
                end
            end
        end else begin : g_inner_data
            always_ff @(posedge clk) begin
                if (v_prev) begin
                    d <= d_prev;
                end
            end
        end
    end

    assign rsp_valid = g_stage[LATENCY-1].v;
    assign rsp_fault = g_stage[LATENCY-1].f;
    assign rsp_data  = g_stage[LATENCY-1].d;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: word array with byte-masked writes and fixed-latency
// reads, plus misaligned / out-of-range fault reporting.
// Ports:
//   i_clk, i_rst_n   clock, async active-low reset
//   i_dmem_addr      byte address (word aligned when legal)
//   i_dmem_ren/wen   read / write strobes, sampled every cycle
//   i_dmem_wdata     lane-aligned write data
//   i_dmem_mask      byte enables for writes
//   o_dmem_rdata     read data, meaningful while o_dmem_valid=1
//   o_dmem_valid     one pulse per accepted read
//   o_dmem_fault     one pulse per faulting request, in its response slot
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          DEPTH        = 1024,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int          READ_LATENCY = 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [31:0]            i_dmem_addr,
    input  logic                   i_dmem_ren,
    input  logic                   i_dmem_wen,
    input  logic [DMEM_WORD_W-1:0] i_dmem_wdata,
    input  logic [DMEM_LANES-1:0]  i_dmem_mask,
    output logic [DMEM_WORD_W-1:0] o_dmem_rdata,
    output logic                   o_dmem_valid,
    output logic                   o_dmem_fault
);

    localparam int AW = $clog2(DEPTH);

    logic [DMEM_WORD_W-1:0] mem [DEPTH];

    logic [31:0]            byte_off;
    logic [31:0]            word_off;
    logic [AW-1:0]          word_idx;
    logic                   misaligned;
    logic                   out_of_range;
    dmem_fault_e            fault_reason;
    logic                   req_fault;
    logic [DMEM_WORD_W-1:0] rd_word;
    logic [DMEM_WORD_W-1:0] wr_bits;

    // Below-base addresses wrap in the subtraction, so they are caught by the
    // explicit compare rather than relying on the index bound.
    assign byte_off     = i_dmem_addr - BASE_ADDR;
    assign word_off     = byte_off >> 2;
    assign word_idx     = word_off[AW-1:0];
    assign misaligned   = (i_dmem_addr[1:0] != 2'b00);
    assign out_of_range = (i_dmem_addr < BASE_ADDR) || (word_off >= 32'(DEPTH));
    assign fault_reason = dmem_classify(misaligned, out_of_range);
    assign req_fault    = (fault_reason != FAULT_NONE);

    // Array read is taken before this edge's write lands: read-before-write.
    assign rd_word = req_fault ? '0 : mem[word_idx];
    assign wr_bits = dmem_lane_bits(i_dmem_mask);

    always_ff @(posedge i_clk) begin
        if (i_dmem_wen && !req_fault) begin
            mem[word_idx] <= (mem[word_idx] & ~wr_bits) | (i_dmem_wdata & wr_bits);
        end
    end

    // Faulting writes ride the same pipe with valid=0 so every fault pulse
    // appears READ_LATENCY cycles after its request.
    dmem_rd_pipe #(
        .LATENCY (READ_LATENCY)
    ) u_rd_pipe (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .req_valid (i_dmem_ren),
        .req_fault ((i_dmem_ren || i_dmem_wen) && req_fault),
        .req_data  (rd_word),
        .rsp_valid (o_dmem_valid),
        .rsp_fault (o_dmem_fault),
        .rsp_data  (o_dmem_rdata)
    );

    a_strobes_known : assert property (@(posedge i_clk) disable iff (!i_rst_n)
        !$isunknown({i_dmem_ren, i_dmem_wen}));

    a_addr_known : assert property (@(posedge i_clk) disable iff (!i_rst_n)
        (i_dmem_ren || i_dmem_wen) |-> !$isunknown(i_dmem_addr));

    a_wr_payload_known : assert property (@(posedge i_clk) disable iff (!i_rst_n)
        i_dmem_wen |-> !$isunknown({i_dmem_mask, i_dmem_wdata}));

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

    localparam int          DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam int          LAT   = 3;
    localparam int          WIN   = 64;

    logic        clk;
    logic        rst_n;
    logic [31:0] addr;
    logic        ren;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic [31:0] rdata;
    logic        valid;
    logic        fault;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int          due;
        bit          valid;
        bit          fault;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model_mem [DEPTH];

    dmem_responder #(
        .DEPTH        (DEPTH),
        .BASE_ADDR    (BASE),
        .READ_LATENCY (LAT)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_dmem_addr  (addr),
        .i_dmem_ren   (ren),
        .i_dmem_wen   (wen),
        .i_dmem_wdata (wdata),
        .i_dmem_mask  (mask),
        .o_dmem_rdata (rdata),
        .o_dmem_valid (valid),
        .o_dmem_fault (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic bit addr_faults(input logic [31:0] a);
        longint off;
        off = longint'(a) - longint'(BASE);
        return (a % 4 != 0) || (off < 0) || (off / 4 >= DEPTH);
    endfunction

    // Called at #1 after a rising edge; the request is sampled at the next edge.
    task automatic issue(input bit r, input bit w, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] m);
        exp_t        e;
        bit          flt;
        int          idx;
        logic [31:0] old;
        addr  = a;
        ren   = r;
        wen   = w;
        wdata = wd;
        mask  = m;
        flt   = addr_faults(a);
        idx   = flt ? 0 : int'((longint'(a) - longint'(BASE)) / 4);
        old   = model_mem[idx];
        if (w && !flt) begin
            for (int b = 0; b < 4; b++)
                if (m[b]) model_mem[idx][8*b +: 8] = wd[8*b +: 8];
        end
        if (r || (w && flt)) begin
            e.due   = cyc + LAT;
            e.valid = r;
            e.fault = flt;
            e.data  = flt ? 32'h0 : old;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        ren = 1'b0;
        wen = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() > 0 && n < LAT + 10) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d responses outstanding, expected 0", sb.size());
            sb.delete();
        end
    endtask

    // Monitor: compare the response slot against the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            while (sb.size() > 0 && sb[0].due < cyc) begin
                e = sb.pop_front();
                checks++;
                errors++;
                $display("FAIL missed_response: due cyc %0d, now %0d", e.due, cyc);
            end
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                check("rsp_valid", {31'b0, valid}, {31'b0, e.valid});
                check("rsp_fault", {31'b0, fault}, {31'b0, e.fault});
                if (e.valid) check("rsp_rdata", rdata, e.data);
            end else if (valid || fault) begin
                check("spurious_valid", {31'b0, valid}, 32'h0);
                check("spurious_fault", {31'b0, fault}, 32'h0);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        addr  = '0;
        ren   = 1'b0;
        wen   = 1'b0;
        wdata = '0;
        mask  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_valid", {31'b0, valid}, 32'h0);
        check("reset_fault", {31'b0, fault}, 32'h0);
        check("reset_rdata", rdata, 32'h0);
        rst_n = 1'b1;
        idle(2);

        // Initialise a window so every later read is of defined data.
        for (int i = 0; i < WIN; i++) issue(0, 1, BASE + 32'(4*i), $urandom, 4'hF);

        // Full-word write and read.
        issue(0, 1, 32'h10, 32'hDEADBEEF, 4'hF);
        issue(1, 0, 32'h10, 32'h0, 4'h0);
        // Byte then half-word lane writes.
        issue(0, 1, 32'h20, 32'h11223344, 4'hF);
        issue(0, 1, 32'h20, 32'h0000AA00, 4'b0010);
        issue(1, 0, 32'h20, 32'h0, 4'h0);
        issue(0, 1, 32'h20, 32'hBBBB0000, 4'b1100);
        issue(1, 0, 32'h20, 32'h0, 4'h0);
        // Back-to-back reads with no bubbles.
        issue(0, 1, 32'h00, 32'h1, 4'hF);
        issue(0, 1, 32'h04, 32'h2, 4'hF);
        issue(0, 1, 32'h08, 32'h3, 4'hF);
        issue(1, 0, 32'h00, 32'h0, 4'h0);
        issue(1, 0, 32'h04, 32'h0, 4'h0);
        issue(1, 0, 32'h08, 32'h0, 4'h0);
        // Read-before-write on simultaneous ren/wen.
        issue(0, 1, 32'h30, 32'h5, 4'hF);
        issue(1, 1, 32'h30, 32'h9, 4'hF);
        issue(1, 0, 32'h30, 32'h0, 4'h0);
        // Faults: out-of-range read, misaligned write, zero-mask write.
        issue(1, 0, BASE + 32'(4*DEPTH), 32'h0, 4'h0);
        issue(0, 1, 32'h42, 32'hFFFFFFFF, 4'hF);
        issue(1, 0, 32'h40, 32'h0, 4'h0);
        issue(0, 1, 32'h44, 32'h12345678, 4'h0);
        issue(1, 0, 32'h44, 32'h0, 4'h0);
        issue(1, 0, 32'h41, 32'h0, 4'hF);
        drain();

        // Randomised traffic over the window plus illegal addresses.
        for (int i = 0; i < 400; i++) begin
            int          sel;
            logic [31:0] a;
            sel = $urandom_range(0, 9);
            if (sel == 0)      a = 32'h1000 | ($urandom & 32'h0FFF_FFFC);
            else if (sel == 1) a = BASE + 32'(4 * $urandom_range(0, WIN-1)) + 32'($urandom_range(1, 3));
            else               a = BASE + 32'(4 * $urandom_range(0, WIN-1));
            issue(1'($urandom), 1'($urandom), a, $urandom, 4'($urandom));
        end
        drain();

        // Reset with two reads in flight.
        issue(1, 0, 32'h10, 32'h0, 4'h0);
        issue(1, 0, 32'h20, 32'h0, 4'h0);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", {31'b0, valid}, 32'h0);
        check("midrst_fault", {31'b0, fault}, 32'h0);
        check("midrst_rdata", rdata, 32'h0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(LAT + 5);
        issue(1, 0, 32'h10, 32'h0, 4'h0);
        issue(1, 0, 32'h20, 32'h0, 4'h0);
        issue(1, 0, 32'h30, 32'h0, 4'h0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
